lcd_bus_writer: RTL and testbench

- Byte-level physical driver for the HD44780-compatible character LCD on the GPIO_1 header.
- Sits directly downstream of the LCD text/formatting engine: accepts one command or data byte per valid/ready handshake.
- Generates the RS/E/D8 bus waveform with HD44780 setup, enable-pulse and hold timing, then enforces the post-write execution delay before accepting the next byte.
- Runs on CLOCK_50; all delays are expressed in clock cycles.

---
 rtl/lcd_bus_writer.sv | 160 ++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer.sv
// Byte-level HD44780 bus driver: a valid/ready byte in, an RS/E/D8 write cycle out.
// Sequences power-up delay, setup, enable pulse, hold and execution wait.
module lcd_bus_writer #(
    parameter int POR_CYC        = 750000,
    parameter int SETUP_CYC      = 2,
    parameter int E_HIGH_CYC     = 12,
    parameter int HOLD_CYC       = 1,
    parameter int SHORT_WAIT_CYC = 2000,
    parameter int LONG_WAIT_CYC  = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_E,
    output logic [7:0] LCD_D
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max_of(max_of(max_of(POR_CYC, SETUP_CYC), max_of(E_HIGH_CYC, HOLD_CYC)),
                                    max_of(SHORT_WAIT_CYC, LONG_WAIT_CYC));
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_E_HIGH  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_WAIT    = 3'd5
    } state_t;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return (rs == 1'b0) && (d[7:2] == 6'd0) && (d != 8'h00);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       d_q, d_d;

    // State register and registered bus outputs; reset also forces E low at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_POWERUP;
            cnt_q   <= CNT_ZERO;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            d_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
        end
    end

    // Next-state sequencing; the power-up phase counts up from the reset value,
    // every later phase loads its length minus one and counts down to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        d_d     = d_q;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == POR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LAST;
                    rs_d    = req_rs;
                    d_d     = req_data;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_E_HIGH;
                    cnt_d   = EHIGH_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_E_HIGH: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_long_cmd(rs_q, d_q) ? LONG_LAST : SHORT_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_POWERUP;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Strobe/handshake outputs follow the state they will be registered with.
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        e_d     = (state_d == ST_E_HIGH);
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign LCD_E     = e_q;
    assign LCD_RS    = rs_q;
    assign LCD_D     = d_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer: a transaction-level timing model predicts
// ready/busy/E per edge; a separate monitor checks each E pulse against queued bytes.
`timescale 1ns/1ps
module tb_lcd_bus_writer;

    localparam int POR   = 10;
    localparam int SETUP = 2;
    localparam int EH    = 4;
    localparam int HOLD  = 1;
    localparam int SHORT = 8;
    localparam int LONG  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       busy;
    logic       LCD_RS;
    logic       LCD_E;
    logic [7:0] LCD_D;

    lcd_bus_writer #(
        .POR_CYC(POR), .SETUP_CYC(SETUP), .E_HIGH_CYC(EH), .HOLD_CYC(HOLD),
        .SHORT_WAIT_CYC(SHORT), .LONG_WAIT_CYC(LONG)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data), .busy(busy),
        .LCD_RS(LCD_RS), .LCD_E(LCD_E), .LCD_D(LCD_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         acc;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    int         edge_cnt = 0;
    bit         m_ready = 1'b0;
    bit         have_acc = 1'b0;
    int         ready_at = POR;
    int         acc_edge = 0;
    logic       m_rs = 1'b0;
    logic [7:0] m_d = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", name, act, exp, $time, edge_cnt);
        end
    endtask

    function automatic int wait_len(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return LONG;
        return SHORT;
    endfunction

    // Reference model: one transfer occupies SETUP+EH+HOLD+wait edges after its accept edge.
    initial begin
        xfer_t x;
        forever begin
            @(posedge clk);
            if (reset) begin
                edge_cnt = 0;
                m_ready  = 1'b0;
                have_acc = 1'b0;
                ready_at = POR;
                m_rs     = 1'b0;
                m_d      = 8'h00;
                exp_q.delete();
                #1;
                check("rst_e", {31'd0, LCD_E}, 32'd0);
                check("rst_ready", {31'd0, req_ready}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd1);
                check("rst_d", {23'd0, LCD_RS, LCD_D}, 32'd0);
            end else begin
                edge_cnt++;
                if (m_ready && req_valid) begin
                    m_rs     = req_rs;
                    m_d      = req_data;
                    acc_edge = edge_cnt;
                    have_acc = 1'b1;
                    m_ready  = 1'b0;
                    ready_at = edge_cnt + SETUP + EH + HOLD + wait_len(req_rs, req_data);
                    x.rs = req_rs;
                    x.d = req_data;
                    x.acc = edge_cnt;
                    exp_q.push_back(x);
                end else if (!m_ready && edge_cnt == ready_at) begin
                    m_ready = 1'b1;
                end
                #1;
                check("ready", {31'd0, req_ready}, {31'd0, m_ready});
                check("busy", {31'd0, busy}, {31'd0, !m_ready});
                check("lcd_e", {31'd0, LCD_E},
                      {31'd0, have_acc && edge_cnt >= acc_edge + SETUP && edge_cnt < acc_edge + SETUP + EH});
                check("lcd_rs", {31'd0, LCD_RS}, {31'd0, m_rs});
                check("lcd_d", {24'd0, LCD_D}, {24'd0, m_d});
            end
        end
    end

    // Scoreboard monitor: every E rising edge must match the oldest accepted byte.
    initial begin
        bit    e_prev;
        xfer_t x;
        e_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                e_prev = 1'b0;
            end else begin
                if (LCD_E && !e_prev) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_pulse", {31'd0, LCD_E}, 32'd0);
                    end else begin
                        x = exp_q.pop_front();
                        check("sb_rs", {31'd0, LCD_RS}, {31'd0, x.rs});
                        check("sb_d", {24'd0, LCD_D}, {24'd0, x.d});
                        check("sb_rise_edge", edge_cnt, x.acc + SETUP);
                    end
                end
                e_prev = LCD_E;
            end
        end
    end

    task automatic send(input logic rs, input logic [7:0] d);
        int n;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("send_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [7:0] rd;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (14) @(negedge clk);

        send(1'b1, 8'h41); idle(20);
        send(1'b0, 8'h01); idle(30);
        send(1'b0, 8'h02); idle(30);
        send(1'b0, 8'h80); idle(20);
        send(1'b0, 8'h00); idle(20);

        send(1'b0, 8'h38); send(1'b0, 8'h0C); send(1'b0, 8'h06); idle(20);

        send(1'b0, 8'h80);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        @(negedge clk);
        idle(20);

        for (int i = 0; i < 25; i++) begin
            rd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rd = 8'($urandom_range(0, 3));
            send(1'($urandom_range(0, 1)), rd);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20));
        end
        idle(30);

        send(1'b1, 8'hA5);
        req_valid = 1'b0;
        n = 0;
        while (!LCD_E && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("e_seen_before_reset", {31'd0, LCD_E}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_e_clear", {31'd0, LCD_E}, 32'd0);
        check("async_ready_clear", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        send(1'b0, 8'h01);
        idle(35);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
